alien_formation_ctrl: RTL and testbench
=======================================

// Module: alien_formation_ctrl
// PURPOSE
// Owns the alien grid: formation origin, march direction, alive mask. Steps the formation on
// frame ticks and reverses with a drop at playfield edges. Per pixel, it drives the cell origin
// and alive flag into the per-alien sprite renderer (alien_left_x/alien_top_y/pixel_on path).
// Takes kill events from the shot-collision logic. Reports all_dead/invaded to the game FSM.
// PARAMETERS
// ALIASIZE 16 sprite edge in px; cell footprint for edge/invade checks
// COLS 8 / ROWS 4 grid size; mask bit = row*COLS+col
// PITCH_LOG2_X 5 / PITCH_LOG2_Y 5 cell pitch = 32 px (power of two)
// START_X 40 / START_Y 48 formation origin after reset/restart
// STEP_X 4 / STEP_Y 8 horizontal march step / drop step, px
// LEFT_BOUND 8 / RIGHT_BOUND 632 playfield x limits (inclusive)
// INVADE_Y 416 bottom-edge y that ends the game
// FRAMES_PER_MOVE 8 frame ticks per move (halved when alive <= half of grid)
// PORTS
// clk in 1 system clock
// rst_n in 1 async active-low reset
// frame_tick in 1 one-cycle pulse per frame (vblank start)
// restart in 1 sync reload of all state to reset values
// kill in 1 one-cycle pulse: clear alien (kill_row,kill_col)
// kill_col in 3 column index 0..COLS-1
// kill_row in 2 row index 0..ROWS-1
// pix_x / pix_y in 10 each current beam position
// alien_left_x / alien_top_y out 10 each cell origin for pixel, 1-cycle latency
// cell_alive out 1 pixel inside grid cell whose alien is alive, 1-cycle latency
// dir out 1 1=right, 0=left
// alive_count out 6 aliens remaining
// move_pulse out 1 one cycle when formation moved/dropped
// all_dead / invaded out 1 each sticky end flags
// BEHAVIOUR
// - Reset (async) and restart (sync, wins over kill/tick): form_x=START_X, form_y=START_Y,
// dir=1, mask all ones, alive_count=32, frame_cnt=0, state MARCH, all registered outputs 0.
// - Lookup pipe: dx=pix_x-form_x, dy=pix_y-form_y (10-bit unsigned wrap); col=dx>>PX, row=dy>>PY.
// Next cycle: alien_left_x=form_x+(col<<PX), alien_top_y=form_y+(row<<PY),
// cell_alive=(col<COLS)&&(row<ROWS)&&mask[row*COLS+col]; outside grid -> cell_alive=0.
// - Edges from registered mask: lc/rc = left/rightmost column with a live alien, br = bottom
// live row. left_edge=form_x+(lc<<PX); right_edge=form_x+(rc<<PX)+ALIASIZE.
// - FSM MARCH: on frame_tick, frame_cnt++; at period-1 (period=FRAMES_PER_MOVE, or /2 if
// alive_count<=16) frame_cnt=0 and a move happens next edge, move_pulse=1 that cycle:
// dir=1 & right_edge+STEP_X>RIGHT_BOUND, or dir=0 & left_edge<LEFT_BOUND+STEP_X ->
// form_y+=STEP_Y, dir flips, form_x unchanged; else form_x+=/-=STEP_X.
// After a drop, form_y+(br<<PY)+ALIASIZE>=INVADE_Y -> invaded=1, state HALT.
// - kill: clears mask bit, alive_count--; kill on dead alien or out-of-range index ignored.
// Mask reaches 0 -> all_dead=1, state HALT.
// - HALT: frame_tick ignored, position frozen, kill still ignored-if-dead; only restart exits.
// - kill + move same cycle: both apply; edge test uses pre-kill mask.
// - rst_n asserted mid-frame: immediate reload; pipe outputs forced 0.
// TESTING
// 1 reset; pix (45,50) -> next cycle left_x=40, top_y=48, cell_alive=1; pix(75,82) -> 72,80,1
// 2 8 frame_ticks -> form_x 44, move_pulse single cycle after 8th tick; 7 ticks -> no move
// 3 89 moves from reset -> 88th form_x=392, 89th drop: form_x=392, form_y=56, dir=0
// 4 kill col7 rows0-3, then march -> right_edge uses col6, drop when form_x+208+4>632; alive=28
// 5 kill 16 aliens -> period 4 ticks; kill all 32 -> all_dead=1, ticks no longer move, restart clears
// 6 INVADE_Y=170: first drop bottom=168 no flag, second drop 176 -> invaded=1, HALT

Source files
------------

// File: rtl/alien_formation_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alien_formation_ctrl
// Purpose  : Alien grid owner: marching origin, alive mask, per-pixel cell lookup.
// Revision : 1.0 - initial release
// ============================================================================
module alien_formation_ctrl #(
    parameter int ALIASIZE        = 16,
    parameter int COLS            = 8,
    parameter int ROWS            = 4,
    parameter int PITCH_LOG2_X    = 5,
    parameter int PITCH_LOG2_Y    = 5,
    parameter int START_X         = 40,
    parameter int START_Y         = 48,
    parameter int STEP_X          = 4,
    parameter int STEP_Y          = 8,
    parameter int LEFT_BOUND      = 8,
    parameter int RIGHT_BOUND     = 632,
    parameter int INVADE_Y        = 416,
    parameter int FRAMES_PER_MOVE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       restart,
    input  logic       kill,
    input  logic [2:0] kill_col,
    input  logic [1:0] kill_row,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic [9:0] alien_left_x,
    output logic [9:0] alien_top_y,
    output logic       cell_alive,
    output logic       dir,
    output logic [5:0] alive_count,
    output logic       move_pulse,
    output logic       all_dead,
    output logic       invaded
);

    localparam int C_CELLS = COLS * ROWS;
    localparam int C_IDX_W = $clog2(C_CELLS);
    localparam int C_COL_W = 10 - PITCH_LOG2_X;
    localparam int C_ROW_W = 10 - PITCH_LOG2_Y;
    localparam int C_CNT_W = $clog2(FRAMES_PER_MOVE) + 1;

    typedef enum logic [0:0] {MARCH = 1'b0, HALT = 1'b1} state_t;

    state_t               r_state, w_state_next;
    logic [9:0]           r_form_x, r_form_y;
    logic                 r_dir;
    logic [C_CELLS-1:0]   r_mask;
    logic [5:0]           r_alive_count;
    logic [C_CNT_W-1:0]   r_frame_cnt;
    logic                 r_move, r_all_dead, r_invaded;
    logic [9:0]           r_left_x, r_top_y;
    logic                 r_cell_alive;

    // Pixel -> cell lookup (offsets wrap in 10 bits, so left/above the grid lands out of range)
    logic [9:0]           w_dx, w_dy;
    logic [C_COL_W-1:0]   w_col;
    logic [C_ROW_W-1:0]   w_row;
    logic                 w_in_grid;
    logic [C_IDX_W-1:0]   w_idx;

    assign w_dx      = pix_x - r_form_x;
    assign w_dy      = pix_y - r_form_y;
    assign w_col     = C_COL_W'(w_dx >> PITCH_LOG2_X);
    assign w_row     = C_ROW_W'(w_dy >> PITCH_LOG2_Y);
    assign w_in_grid = (int'(w_col) < COLS) && (int'(w_row) < ROWS);
    assign w_idx     = C_IDX_W'(int'(w_row) * COLS + int'(w_col));

    // Occupied extents of the live formation
    logic [COLS-1:0]      w_col_any;
    logic [ROWS-1:0]      w_row_any;
    logic [C_COL_W-1:0]   w_lc, w_rc;
    logic [C_ROW_W-1:0]   w_br;

    always_comb begin
        w_col_any = '0;
        w_row_any = '0;
        w_lc      = '0;
        w_rc      = '0;
        w_br      = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r_mask[r*COLS+c]) begin
                    w_col_any[c] = 1'b1;
                    w_row_any[r] = 1'b1;
                end
            end
        end
        for (int c = COLS - 1; c >= 0; c--) begin
            if (w_col_any[c]) w_lc = C_COL_W'(c);
        end
        for (int c = 0; c < COLS; c++) begin
            if (w_col_any[c]) w_rc = C_COL_W'(c);
        end
        for (int r = 0; r < ROWS; r++) begin
            if (w_row_any[r]) w_br = C_ROW_W'(r);
        end
    end

    logic [11:0] w_left_edge, w_right_edge, w_bottom;
    logic [9:0]  w_drop_y;
    logic        w_hit_edge, w_invade, w_do_move;

    assign w_left_edge  = 12'(r_form_x) + 12'({w_lc, {PITCH_LOG2_X{1'b0}}});
    assign w_right_edge = 12'(r_form_x) + 12'({w_rc, {PITCH_LOG2_X{1'b0}}}) + 12'(ALIASIZE);
    assign w_hit_edge   = r_dir ? (w_right_edge + 12'(STEP_X) > 12'(RIGHT_BOUND))
                                : (w_left_edge < 12'(LEFT_BOUND + STEP_X));
    assign w_drop_y     = r_form_y + 10'(STEP_Y);
    assign w_bottom     = 12'(w_drop_y) + 12'({w_br, {PITCH_LOG2_Y{1'b0}}}) + 12'(ALIASIZE);
    assign w_invade     = w_bottom >= 12'(INVADE_Y);
    assign w_do_move    = r_move && (r_state == MARCH);

    // Kill handling; edge test above still sees the pre-kill mask
    logic [C_IDX_W-1:0] w_kill_idx;
    logic               w_kill_hit, w_all_gone;
    logic [C_CELLS-1:0] w_mask_next;

    assign w_kill_idx  = C_IDX_W'(int'(kill_row) * COLS + int'(kill_col));
    assign w_kill_hit  = kill && (int'(kill_col) < COLS) && (int'(kill_row) < ROWS)
                         && r_mask[w_kill_idx];
    assign w_mask_next = w_kill_hit ? (r_mask & ~(C_CELLS'(1) << w_kill_idx)) : r_mask;
    assign w_all_gone  = w_kill_hit && (w_mask_next == '0);

    logic [C_CNT_W-1:0] w_period_last;
    logic               w_tick_wrap;

    assign w_period_last = (r_alive_count <= 6'(C_CELLS / 2)) ? C_CNT_W'(FRAMES_PER_MOVE / 2 - 1)
                                                               : C_CNT_W'(FRAMES_PER_MOVE - 1);
    assign w_tick_wrap   = frame_tick && (r_state == MARCH) && (r_frame_cnt >= w_period_last);

    always_comb begin
        w_state_next = r_state;
        if (restart) begin
            w_state_next = MARCH;
        end else if (r_state == MARCH && ((w_do_move && w_hit_edge && w_invade) || w_all_gone)) begin
            w_state_next = HALT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= MARCH;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_form_x      <= 10'(START_X);
            r_form_y      <= 10'(START_Y);
            r_dir         <= 1'b1;
            r_mask        <= '1;
            r_alive_count <= 6'(C_CELLS);
            r_frame_cnt   <= '0;
            r_move        <= 1'b0;
            r_all_dead    <= 1'b0;
            r_invaded     <= 1'b0;
            r_left_x      <= '0;
            r_top_y       <= '0;
            r_cell_alive  <= 1'b0;
        end else if (restart) begin
            r_form_x      <= 10'(START_X);
            r_form_y      <= 10'(START_Y);
            r_dir         <= 1'b1;
            r_mask        <= '1;
            r_alive_count <= 6'(C_CELLS);
            r_frame_cnt   <= '0;
            r_move        <= 1'b0;
            r_all_dead    <= 1'b0;
            r_invaded     <= 1'b0;
            r_left_x      <= '0;
            r_top_y       <= '0;
            r_cell_alive  <= 1'b0;
        end else begin
            r_left_x     <= r_form_x + {w_col, {PITCH_LOG2_X{1'b0}}};
            r_top_y      <= r_form_y + {w_row, {PITCH_LOG2_Y{1'b0}}};
            r_cell_alive <= w_in_grid && r_mask[w_idx];

            r_mask <= w_mask_next;
            if (w_kill_hit) r_alive_count <= r_alive_count - 6'd1;
            if (w_all_gone) r_all_dead    <= 1'b1;

            if (w_do_move) begin
                if (w_hit_edge) begin
                    r_form_y <= w_drop_y;
                    r_dir    <= ~r_dir;
                    if (w_invade) r_invaded <= 1'b1;
                end else if (r_dir) begin
                    r_form_x <= r_form_x + 10'(STEP_X);
                end else begin
                    r_form_x <= r_form_x - 10'(STEP_X);
                end
            end

            if (frame_tick && r_state == MARCH)
                r_frame_cnt <= w_tick_wrap ? '0 : r_frame_cnt + 1'b1;
            r_move <= w_tick_wrap && (w_state_next == MARCH);
        end
    end

    assign alien_left_x = r_left_x;
    assign alien_top_y  = r_top_y;
    assign cell_alive   = r_cell_alive;
    assign dir          = r_dir;
    assign alive_count  = r_alive_count;
    assign move_pulse   = r_move;
    assign all_dead     = r_all_dead;
    assign invaded      = r_invaded;

endmodule
`default_nettype wire

// File: tb/tb_alien_formation_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alien_formation_ctrl
// Purpose  : Self-checking bench for alien_formation_ctrl against a grid model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alien_formation_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0, restart = 1'b0, kill = 1'b0;
    logic [2:0] kill_col = '0;
    logic [1:0] kill_row = '0;
    logic [9:0] pix_x = '0, pix_y = '0;
    logic [9:0] alien_left_x, alien_top_y;
    logic       cell_alive, dir, move_pulse, all_dead, invaded;
    logic [5:0] alive_count;
    logic [9:0] inv_left_x, inv_top_y;
    logic       inv_cell, inv_dir, inv_move, inv_dead, inv_invaded;
    logic [5:0] inv_count;

    always #5 clk = ~clk;

    alien_formation_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .restart(restart), .kill(kill),
        .kill_col(kill_col), .kill_row(kill_row), .pix_x(pix_x), .pix_y(pix_y),
        .alien_left_x(alien_left_x), .alien_top_y(alien_top_y), .cell_alive(cell_alive),
        .dir(dir), .alive_count(alive_count), .move_pulse(move_pulse),
        .all_dead(all_dead), .invaded(invaded)
    );

    alien_formation_ctrl #(.INVADE_Y(170)) dut_inv (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .restart(restart), .kill(kill),
        .kill_col(kill_col), .kill_row(kill_row), .pix_x(pix_x), .pix_y(pix_y),
        .alien_left_x(inv_left_x), .alien_top_y(inv_top_y), .cell_alive(inv_cell),
        .dir(inv_dir), .alive_count(inv_count), .move_pulse(inv_move),
        .all_dead(inv_dead), .invaded(inv_invaded)
    );

    int nvec = 0;
    int nfail = 0;

    // Behavioural model of the formation
    int m_fx, m_fy, m_frames, m_left, m_top, m_moves;
    bit m_dir, m_pend, m_halt, m_dead, m_inv, m_cell;
    bit m_alive[4][8];

    function automatic int cnt_alive();
        int n = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++) n += m_alive[r][c];
        return n;
    endfunction

    task automatic model_reset();
        m_fx = 40; m_fy = 48; m_dir = 1; m_frames = 0; m_pend = 0;
        m_halt = 0; m_dead = 0; m_inv = 0; m_left = 0; m_top = 0; m_cell = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++) m_alive[r][c] = 1;
    endtask

    task automatic model_edge(input bit t, input bit k, input int kr, input int kc,
                              input bit rs, input int px, input int py);
        int lc, rc, br, cnt, dx, dy, col, row, period;
        bit old_halt, hit, new_pend;
        if (rs) begin
            model_reset();
            return;
        end
        old_halt = m_halt;
        cnt = cnt_alive();
        dx = ((px - m_fx) % 1024 + 1024) % 1024;
        dy = ((py - m_fy) % 1024 + 1024) % 1024;
        col = dx / 32; row = dy / 32;
        m_left = (m_fx + col * 32) % 1024;
        m_top  = (m_fy + row * 32) % 1024;
        m_cell = (col < 8 && row < 4) ? m_alive[row][col] : 1'b0;
        lc = 99; rc = -1; br = -1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++)
                if (m_alive[r][c]) begin
                    if (c < lc) lc = c;
                    if (c > rc) rc = c;
                    if (r > br) br = r;
                end
        if (m_pend && !old_halt) begin
            m_moves++;
            hit = m_dir ? (m_fx + rc * 32 + 16 + 4 > 632) : (m_fx + lc * 32 < 12);
            if (hit) begin
                m_fy += 8;
                m_dir = !m_dir;
                if (m_fy + br * 32 + 16 >= 416) begin m_inv = 1; m_halt = 1; end
            end else begin
                m_fx = m_dir ? m_fx + 4 : m_fx - 4;
            end
        end
        new_pend = 0;
        if (t && !old_halt) begin
            period = (cnt <= 16) ? 4 : 8;
            if (m_frames >= period - 1) begin m_frames = 0; new_pend = 1; end
            else m_frames++;
        end
        if (k && kr < 4 && kc < 8 && m_alive[kr][kc]) begin
            m_alive[kr][kc] = 0;
            if (cnt_alive() == 0) begin m_dead = 1; m_halt = 1; end
        end
        m_pend = new_pend && !m_halt;
    endtask

    task automatic compare_all();
        nvec++;
        if (alien_left_x !== 10'(m_left) || alien_top_y !== 10'(m_top) || cell_alive !== m_cell ||
            dir !== m_dir || alive_count !== 6'(cnt_alive()) || move_pulse !== m_pend ||
            all_dead !== m_dead || invaded !== m_inv) begin
            nfail++;
            $display("FAIL model @%0t: got x=%0d y=%0d cell=%0b dir=%0b n=%0d mv=%0b dead=%0b inv=%0b | want x=%0d y=%0d cell=%0b dir=%0b n=%0d mv=%0b dead=%0b inv=%0b",
                     $time, alien_left_x, alien_top_y, cell_alive, dir, alive_count, move_pulse,
                     all_dead, invaded, m_left, m_top, m_cell, m_dir, cnt_alive(), m_pend, m_dead, m_inv);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit t, input bit k, input int kr, input int kc,
                       input bit rs, input int px, input int py);
        frame_tick = t; kill = k; kill_row = 2'(kr); kill_col = 3'(kc);
        restart = rs; pix_x = 10'(px); pix_y = 10'(py);
        @(posedge clk);
        model_edge(t, k, kr, kc, rs, px, py);
        #1;
        compare_all();
        frame_tick = 0; kill = 0; restart = 0;
    endtask

    task automatic idle();                       cyc(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic tick_once();                  cyc(1, 0, 0, 0, 0, 0, 0); idle(); endtask
    task automatic do_restart();                 cyc(0, 0, 0, 0, 1, 0, 0); endtask
    task automatic kill_at(input int r, input int c); cyc(0, 1, r, c, 0, 0, 0); endtask

    task automatic probe(input string nm, input int px, input int py,
                         input int ex, input int ey, input bit ec);
        cyc(0, 0, 0, 0, 0, px, py);
        chk({nm, ".left_x"}, 32'(alien_left_x), 32'(ex));
        chk({nm, ".top_y"},  32'(alien_top_y),  32'(ey));
        chk({nm, ".alive"},  32'(cell_alive),   32'(ec));
    endtask

    task automatic do_moves(input int target);
        int budget = 4000;
        while (m_moves < target && budget > 0) begin
            tick_once();
            budget--;
        end
        if (m_moves < target) begin
            nvec++; nfail++;
            $display("FAIL move_timeout: got %0d moves want %0d", m_moves, target);
        end
    endtask

    typedef struct {
        int px, py, ex, ey;
        bit ec;
    } vec_t;
    vec_t tbl[6];

    initial begin
        tbl[0] = '{45, 50, 40, 48, 1'b1};
        tbl[1] = '{75, 82, 72, 80, 1'b1};
        tbl[2] = '{39, 48, 8, 48, 1'b0};
        tbl[3] = '{295, 175, 264, 144, 1'b1};
        tbl[4] = '{296, 48, 296, 48, 1'b0};
        tbl[5] = '{40, 176, 40, 176, 1'b0};

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.left_x", 32'(alien_left_x), 0);
        chk("rst.cell", 32'(cell_alive), 0);
        chk("rst.dir", 32'(dir), 1);
        chk("rst.count", 32'(alive_count), 32);
        chk("rst.flags", {29'd0, move_pulse, all_dead, invaded}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) probe($sformatf("tbl%0d", i), tbl[i].px, tbl[i].py, tbl[i].ex, tbl[i].ey, tbl[i].ec);

        // 7 ticks: no move; 8th tick: single-cycle move_pulse then form_x=44
        m_moves = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(1, 0, 0, 0, 0, 0, 0);
            chk("t7.nomove", 32'(move_pulse), 0);
            idle();
        end
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("t8.pulse", 32'(move_pulse), 1);
        idle();
        chk("t8.pulse_end", 32'(move_pulse), 0);
        probe("t8.pos", 49, 50, 44, 48, 1);

        // Right-edge drop after 89 moves
        do_moves(88);
        probe("m88", 392, 48, 392, 48, 1);
        do_moves(89);
        probe("m89", 392, 56, 392, 56, 1);
        chk("m89.dir", 32'(dir), 0);

        // Asynchronous reset in mid-cycle
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.left_x", 32'(alien_left_x), 0);
        chk("arst.dir", 32'(dir), 1);
        @(negedge clk);
        rst_n = 1'b1;
        probe("arst.pos", 45, 50, 40, 48, 1);

        // Column 7 removed: right edge from column 6
        do_restart();
        for (int r = 0; r < 4; r++) kill_at(r, 7);
        kill_at(2, 7);
        chk("k7.count", 32'(alive_count), 28);
        m_moves = 0;
        do_moves(96);
        probe("k7.m96", 424, 48, 424, 48, 1);
        chk("k7.dir96", 32'(dir), 1);
        do_moves(97);
        probe("k7.m97", 424, 56, 424, 56, 1);
        chk("k7.dir97", 32'(dir), 0);

        // Half the grid dead: period 4; all dead: halt
        do_restart();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 8; c++) kill_at(r, c);
        chk("half.count", 32'(alive_count), 16);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0, 0, 0, 0);
            chk("half.pulse", 32'(move_pulse), (i == 3) ? 1 : 0);
        end
        idle();
        probe("half.pos", 44, 112, 44, 112, 1);
        for (int r = 2; r < 4; r++)
            for (int c = 0; c < 8; c++) kill_at(r, c);
        chk("dead.flag", 32'(all_dead), 1);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 0, 0, 0, 0, 0);
            idle();
            chk("dead.nomove", 32'(move_pulse), 0);
        end
        probe("dead.pos", 44, 112, 44, 112, 0);
        do_restart();
        chk("rs.dead", 32'(all_dead), 0);
        chk("rs.count", 32'(alive_count), 32);

        // Invasion on the second drop for the INVADE_Y=170 instance
        m_moves = 0;
        do_moves(89);
        chk("inv.first", 32'(inv_invaded), 0);
        do_moves(186);
        chk("inv.second", 32'(inv_invaded), 1);
        chk("inv.default", 32'(invaded), 0);
        for (int i = 0; i < 10; i++) begin
            tick_once();
            chk("inv.halt", 32'(inv_move), 0);
        end

        // Randomized traffic against the model
        do_restart();
        for (int i = 0; i < 800; i++) begin
            cyc((i % 2) == 0, $urandom_range(0, 11) == 0,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 0,
                (m_fx - 16 + int'($urandom_range(0, 300)) + 1024) % 1024,
                (m_fy - 16 + int'($urandom_range(0, 160)) + 1024) % 1024);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
